// File: rtl/ubit_pkg.sv
// Shared types for the unary-to-binary decoder.
// Holds the FSM state type and the window length helper.
package ubit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int wlen(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/ubit_window_ctr.sv
// Sample and window counters for the decoder.
// Flags the final valid sample of the final window.
module ubit_window_ctr
  import ubit_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_WIN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_vld,
  output logic o_last
);

  localparam int WLEN  = wlen(WIDTH);
  localparam int SMP_W = WIDTH - 1;
  localparam int WIN_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

  logic [SMP_W-1:0] r_smp;
  logic [WIN_W-1:0] r_win;
  logic             w_smp_last;
  logic             w_win_last;
  logic             w_step;

  assign w_smp_last = (r_smp == SMP_W'(WLEN - 1));
  assign w_win_last = (r_win == WIN_W'(NUM_WIN - 1));
  assign w_step     = i_en && i_vld;
  assign o_last     = w_step && w_smp_last && w_win_last;

  // Count valid samples; wrap into the next window at WLEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp <= '0;
      r_win <= '0;
    end else if (i_clr) begin
      r_smp <= '0;
      r_win <= '0;
    end else if (w_step) begin
      if (w_smp_last) begin
        r_smp <= '0;
        r_win <= w_win_last ? '0 : r_win + 1'b1;
      end else begin
        r_smp <= r_smp + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ubit_decoder.sv
// Counts 1s in a unary product stream over NUM_WIN windows
// and hands the binary total out on a valid/ready port.
module ubit_decoder
  import ubit_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_WIN = 1,
  parameter int ACC_W   = WIDTH + $clog2(NUM_WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_bit_vld,
  input  logic             i_bit,
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_data,
  output logic             o_overrun
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_run;
  logic             w_clr;
  logic             w_en;
  logic             w_last;
  logic             w_done;
  logic             w_accept;

  assign w_run     = (r_state == RUN);
  assign w_clr     = w_run ? i_abort : (i_start && !i_abort);
  assign w_en      = w_run && !i_abort;
  assign w_done    = w_last;
  assign w_accept  = o_valid && i_ready;
  assign w_acc_nxt = r_acc + ACC_W'(i_bit);
  assign o_busy    = w_run;

  ubit_window_ctr #(
    .WIDTH   (WIDTH),
    .NUM_WIN (NUM_WIN)
  ) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_vld  (i_bit_vld),
    .o_last (w_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: abort beats start and completion.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (i_start && !i_abort) w_state_nxt = RUN;
      RUN:  if (i_abort || w_last)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ones accumulator, cleared on start and on abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_clr) begin
      r_acc <= '0;
    end else if (w_en && i_bit_vld) begin
      r_acc <= w_acc_nxt;
    end
  end

  // Result register with handshake and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_overrun <= 1'b0;
    end else if (w_done) begin
      o_valid <= 1'b1;
      o_data  <= w_acc_nxt;
      if (o_valid && !i_ready) o_overrun <= 1'b1;
    end else if (w_accept) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ubit_decoder.sv
// Randomised and directed bench for ubit_decoder.
// Two instances (1 and 4 windows) share one stimulus stream.
module tb_ubit_decoder;

  localparam int WIDTH = 8;
  localparam int WL    = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort, i_bit_vld, i_bit, i_ready;
  logic        o_busy1, o_valid1, o_ovr1;
  logic [8:0]  o_data1;
  logic        o_busy4, o_valid4, o_ovr4;
  logic [10:0] o_data4;

  int n_chk = 0;
  int n_err = 0;

  int nwin[2] = '{1, 4};
  bit m_run[2];
  int m_smp[2];
  int m_ones[2];
  bit m_vld[2];
  int m_data[2];
  bit m_ovr[2];

  always #5 clk = ~clk;

  ubit_decoder #(.WIDTH(WIDTH), .NUM_WIN(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_bit_vld(i_bit_vld), .i_bit(i_bit), .o_busy(o_busy1),
    .o_valid(o_valid1), .i_ready(i_ready), .o_data(o_data1),
    .o_overrun(o_ovr1)
  );

  ubit_decoder #(.WIDTH(WIDTH), .NUM_WIN(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_bit_vld(i_bit_vld), .i_bit(i_bit), .o_busy(o_busy4),
    .o_valid(o_valid4), .i_ready(i_ready), .o_data(o_data4),
    .o_overrun(o_ovr4)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 50)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_smp[k] = 0; m_ones[k] = 0;
      m_vld[k] = 0; m_data[k] = 0; m_ovr[k] = 0;
    end
  endfunction

  // State after the next rising edge, given this cycle's inputs.
  function automatic void model_step(input bit s, a, v, b, r);
    for (int k = 0; k < 2; k++) begin
      bit done = 0;
      bit acc = m_vld[k] && r;
      if (!m_run[k]) begin
        if (s && !a) begin
          m_run[k] = 1; m_smp[k] = 0; m_ones[k] = 0;
        end
      end else if (a) begin
        m_run[k] = 0; m_smp[k] = 0; m_ones[k] = 0;
      end else if (v) begin
        m_smp[k]++;
        m_ones[k] += int'(b);
        if (m_smp[k] == nwin[k] * WL) begin
          done = 1;
          m_run[k] = 0;
        end
      end
      if (done) begin
        if (m_vld[k] && !acc) m_ovr[k] = 1;
        m_data[k] = m_ones[k];
        m_vld[k] = 1;
      end else if (acc) begin
        m_vld[k] = 0;
      end
    end
  endfunction

  task automatic check_all();
    check("busy1",  int'(o_busy1),  int'(m_run[0]));
    check("valid1", int'(o_valid1), int'(m_vld[0]));
    check("data1",  int'(o_data1),  m_data[0]);
    check("ovr1",   int'(o_ovr1),   int'(m_ovr[0]));
    check("busy4",  int'(o_busy4),  int'(m_run[1]));
    check("valid4", int'(o_valid4), int'(m_vld[1]));
    check("data4",  int'(o_data4),  m_data[1]);
    check("ovr4",   int'(o_ovr4),   int'(m_ovr[1]));
  endtask

  task automatic cyc(input bit s, a, v, b, r);
    i_start = s; i_abort = a; i_bit_vld = v; i_bit = b; i_ready = r;
    model_step(s, a, v, b, r);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_start = 0; i_abort = 0; i_bit_vld = 0; i_bit = 0; i_ready = 0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // All ones, one window.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < WL; i++) cyc(0, 0, 1, 1, 0);
    check("s1_data", int'(o_data1), 128);
    check("s1_valid", int'(o_valid1), 1);
    check("s1_busy", int'(o_busy1), 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);

    // Product stream at 1/4 density.
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < WL; i++) cyc(0, 0, 1, (i & 3) == 3, 1);
    check("s2_data", int'(o_data1), 32);
    cyc(0, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < WL; i++) cyc(0, 0, 1, 0, 1);
    check("s2_zero", int'(o_data1), 0);
    cyc(0, 1, 0, 0, 1);

    // Alternating valid.
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 2 * WL; i++) cyc(0, 0, (i & 1) == 0, 1, 0);
    check("s3_data", int'(o_data1), 128);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Four windows, then an unread second result.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4 * WL; i++) cyc(0, 0, 1, 1, 0);
    check("s4_data", int'(o_data4), 512);
    check("s4_ovr0", int'(o_ovr4), 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4 * WL; i++) cyc(0, 0, 1, 1, 0);
    check("s4_data2", int'(o_data4), 512);
    check("s4_ovr", int'(o_ovr4), 1);
    do_rst();

    // Abort then restart; reset mid-run.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    check("s5_abort_valid", int'(o_valid1), 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < WL; i++) cyc(0, 0, 1, 0, 0);
    check("s5_data", int'(o_data1), 0);
    check("s5_valid", int'(o_valid1), 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) cyc(0, 0, 1, 1, 0);
    do_rst();
    check("s5_rst_busy", int'(o_busy1), 0);

    // Accept on the completion edge of result 2.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < WL; i++) cyc(0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < WL; i++) cyc(0, 0, 1, 0, i == WL - 1);
    check("s6_data", int'(o_data1), 0);
    check("s6_valid", int'(o_valid1), 1);
    check("s6_ovr", int'(o_ovr1), 0);
    do_rst();

    // Random traffic.
    for (int i = 0; i < 6000; i++) begin
      cyc($urandom_range(0, 39) == 0,
          $urandom_range(0, 299) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4999) == 0) do_rst();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
